// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the TinyRISC-V pipeline (slave) and pipe_hazard_ctrl (master).
// Also supplies default widths for REG_ADDR_WIDTH / RV32_ADDR_WIDTH when the core does not.
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef RV32_ADDR_WIDTH
`define RV32_ADDR_WIDTH 32
`endif

interface pipe_hazard_ctrl_if;
  logic [`REG_ADDR_WIDTH-1:0]  id_rs1_addr_i;
  logic                        id_rs1_rd_en_i;
  logic [`REG_ADDR_WIDTH-1:0]  id_rs2_addr_i;
  logic                        id_rs2_rd_en_i;
  logic [`REG_ADDR_WIDTH-1:0]  ex_rd_addr_i;
  logic                        ex_is_load_i;
  logic                        ex_jump_i;
  logic [`RV32_ADDR_WIDTH-1:0] ex_jump_addr_i;
  logic                        muldiv_start_i;
  logic                        muldiv_done_i;
  logic                        pc_stall_o;
  logic                        if_id_stall_o;
  logic                        id_ex_stall_o;
  logic                        if_id_flush_o;
  logic                        id_ex_flush_o;
  logic                        pc_jump_o;
  logic [`RV32_ADDR_WIDTH-1:0] pc_jump_addr_o;
  logic                        muldiv_timeout_o;

  modport master (
    input  id_rs1_addr_i, id_rs1_rd_en_i, id_rs2_addr_i, id_rs2_rd_en_i,
    input  ex_rd_addr_i, ex_is_load_i, ex_jump_i, ex_jump_addr_i,
    input  muldiv_start_i, muldiv_done_i,
    output pc_stall_o, if_id_stall_o, id_ex_stall_o, if_id_flush_o, id_ex_flush_o,
    output pc_jump_o, pc_jump_addr_o, muldiv_timeout_o
  );

  modport slave (
    output id_rs1_addr_i, id_rs1_rd_en_i, id_rs2_addr_i, id_rs2_rd_en_i,
    output ex_rd_addr_i, ex_is_load_i, ex_jump_i, ex_jump_addr_i,
    output muldiv_start_i, muldiv_done_i,
    input  pc_stall_o, if_id_stall_o, id_ex_stall_o, if_id_flush_o, id_ex_flush_o,
    input  pc_jump_o, pc_jump_addr_o, muldiv_timeout_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencing for jumps, multi-cycle mul/div (with watchdog) and load-use hazards.
// Optional saturating stall-cycle counter on stall_cnt_o when PIPE_STALL_CNT_EN is defined.
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef RV32_ADDR_WIDTH
`define RV32_ADDR_WIDTH 32
`endif

module pipe_hazard_ctrl #(
  parameter int unsigned MULDIV_TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
`ifdef PIPE_STALL_CNT_EN
  output logic [31:0]        stall_cnt_o,
`endif
  pipe_hazard_ctrl_if.master bus_io
);

  typedef enum logic {RUN, MULDIV_WAIT} state_e;

  localparam logic [7:0] WAIT_LIMIT = 8'(MULDIV_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       load_use;

  assign load_use = bus_io.ex_is_load_i && (bus_io.ex_rd_addr_i != '0) &&
                    ((bus_io.id_rs1_rd_en_i && (bus_io.id_rs1_addr_i == bus_io.ex_rd_addr_i)) ||
                     (bus_io.id_rs2_rd_en_i && (bus_io.id_rs2_addr_i == bus_io.ex_rd_addr_i)));

  always_comb begin
    state_d                 = state_q;
    wait_cnt_d              = wait_cnt_q;
    bus_io.pc_stall_o       = 1'b0;
    bus_io.if_id_stall_o    = 1'b0;
    bus_io.id_ex_stall_o    = 1'b0;
    bus_io.if_id_flush_o    = 1'b0;
    bus_io.id_ex_flush_o    = 1'b0;
    bus_io.pc_jump_o        = 1'b0;
    bus_io.pc_jump_addr_o   = '0;
    bus_io.muldiv_timeout_o = 1'b0;
    if (rst) begin
      // Hold both buffers as NOPs while in reset
      bus_io.if_id_flush_o = 1'b1;
      bus_io.id_ex_flush_o = 1'b1;
      state_d              = RUN;
      wait_cnt_d           = '0;
    end else begin
      case (state_q)
        RUN: begin
          if (bus_io.ex_jump_i) begin
            bus_io.pc_jump_o      = 1'b1;
            bus_io.pc_jump_addr_o = bus_io.ex_jump_addr_i;
            bus_io.if_id_flush_o  = 1'b1;
            bus_io.id_ex_flush_o  = 1'b1;
          end else if (bus_io.muldiv_start_i && !bus_io.muldiv_done_i) begin
            bus_io.pc_stall_o    = 1'b1;
            bus_io.if_id_stall_o = 1'b1;
            bus_io.id_ex_stall_o = 1'b1;
            state_d              = MULDIV_WAIT;
            wait_cnt_d           = 8'd1;
          end else if (bus_io.muldiv_start_i) begin
            state_d = RUN;
          end else if (load_use) begin
            bus_io.pc_stall_o    = 1'b1;
            bus_io.if_id_stall_o = 1'b1;
            bus_io.id_ex_flush_o = 1'b1;
          end
        end
        MULDIV_WAIT: begin
          if (bus_io.muldiv_done_i) begin
            state_d    = RUN;
            wait_cnt_d = '0;
          end else if (wait_cnt_q == WAIT_LIMIT) begin
            // Watchdog: drop the stuck EX instruction and resume
            bus_io.muldiv_timeout_o = 1'b1;
            bus_io.id_ex_flush_o    = 1'b1;
            state_d                 = RUN;
            wait_cnt_d              = '0;
          end else begin
            bus_io.pc_stall_o    = 1'b1;
            bus_io.if_id_stall_o = 1'b1;
            bus_io.id_ex_stall_o = 1'b1;
            wait_cnt_d           = wait_cnt_q + 8'd1;
          end
        end
        default: begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

`ifdef PIPE_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (bus_io.pc_stall_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl with MULDIV_TIMEOUT = 8.
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  pipe_hazard_ctrl_if bus_if ();

`ifdef PIPE_STALL_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] cnt_base;
`endif

  pipe_hazard_ctrl #(.MULDIV_TIMEOUT(8)) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef PIPE_STALL_CNT_EN
    .stall_cnt_o (stall_cnt),
`endif
    .bus_io      (bus_if.master)
  );

  always #5 clk = ~clk;

  // {pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_flush, pc_jump, timeout}
  logic [6:0] ctl;
  assign ctl = {bus_if.pc_stall_o, bus_if.if_id_stall_o, bus_if.id_ex_stall_o,
                bus_if.if_id_flush_o, bus_if.id_ex_flush_o, bus_if.pc_jump_o,
                bus_if.muldiv_timeout_o};

  localparam logic [6:0] C_IDLE  = 7'b000_0000;
  localparam logic [6:0] C_FLUSH = 7'b000_1100;
  localparam logic [6:0] C_LU    = 7'b110_0100;
  localparam logic [6:0] C_JUMP  = 7'b000_1110;
  localparam logic [6:0] C_MD    = 7'b111_0000;
  localparam logic [6:0] C_TMO   = 7'b000_0101;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus_if.id_rs1_addr_i  = '0;
    bus_if.id_rs1_rd_en_i = 1'b0;
    bus_if.id_rs2_addr_i  = '0;
    bus_if.id_rs2_rd_en_i = 1'b0;
    bus_if.ex_rd_addr_i   = '0;
    bus_if.ex_is_load_i   = 1'b0;
    bus_if.ex_jump_i      = 1'b0;
    bus_if.ex_jump_addr_i = '0;
    bus_if.muldiv_start_i = 1'b0;
    bus_if.muldiv_done_i  = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    bus_if.ex_is_load_i   = 1'b1;
    bus_if.ex_rd_addr_i   = rd;
    bus_if.id_rs2_addr_i  = 5'd5;
    bus_if.id_rs2_rd_en_i = 1'b1;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    bus_if.ex_jump_i      = 1'b1;
    bus_if.ex_jump_addr_i = 32'hDEAD_BEEF;
    tick();
    tick();
    #1;
    check("rst_ctl", 32'(ctl), 32'(C_FLUSH));
    check("rst_addr", bus_if.pc_jump_addr_o, 32'h0);
`ifdef PIPE_STALL_CNT_EN
    check("rst_cnt", stall_cnt, 32'h0);
`endif
    clear_inputs();
    rst = 1'b0;
    tick();
    #1;
    check("idle", 32'(ctl), 32'(C_IDLE));

    // Load-use on rs2
    set_load_use(5'd5);
    #1;
    check("lu_rs2", 32'(ctl), 32'(C_LU));
    tick();
    bus_if.ex_is_load_i = 1'b0;
    #1;
    check("lu_bubble", 32'(ctl), 32'(C_IDLE));

    // Hazard through x0 never stalls
    set_load_use(5'd0);
    bus_if.id_rs2_addr_i = 5'd0;
    #1;
    check("lu_x0", 32'(ctl), 32'(C_IDLE));
    clear_inputs();

    // rs1 match only counts when rs1 is read
    bus_if.ex_is_load_i  = 1'b1;
    bus_if.ex_rd_addr_i  = 5'd9;
    bus_if.id_rs1_addr_i = 5'd9;
    #1;
    check("lu_rs1_noen", 32'(ctl), 32'(C_IDLE));
    bus_if.id_rs1_rd_en_i = 1'b1;
    #1;
    check("lu_rs1", 32'(ctl), 32'(C_LU));
    tick();
    clear_inputs();

    // Jump wins over load-use and mul/div start
    set_load_use(5'd5);
    bus_if.ex_jump_i      = 1'b1;
    bus_if.ex_jump_addr_i = 32'h0000_0100;
    bus_if.muldiv_start_i = 1'b1;
    #1;
    check("jump_ctl", 32'(ctl), 32'(C_JUMP));
    check("jump_addr", bus_if.pc_jump_addr_o, 32'h0000_0100);
    tick();
    clear_inputs();
    #1;
    check("jump_after", 32'(ctl), 32'(C_IDLE));
    check("jump_addr_clr", bus_if.pc_jump_addr_o, 32'h0);

    // Single-cycle mul/div
    bus_if.muldiv_start_i = 1'b1;
    bus_if.muldiv_done_i  = 1'b1;
    #1;
    check("md_1cyc", 32'(ctl), 32'(C_IDLE));
    tick();
    clear_inputs();
    #1;
    check("md_1cyc_after", 32'(ctl), 32'(C_IDLE));

    // mul/div done at cycle 4
`ifdef PIPE_STALL_CNT_EN
    cnt_base = stall_cnt;
`endif
    bus_if.muldiv_start_i = 1'b1;
    #1;
    check("md_c0", 32'(ctl), 32'(C_MD));
    tick();
    bus_if.muldiv_start_i = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      #1;
      check($sformatf("md_c%0d", c), 32'(ctl), 32'(C_MD));
      tick();
    end
    bus_if.muldiv_done_i = 1'b1;
    #1;
    check("md_c4_done", 32'(ctl), 32'(C_IDLE));
    tick();
    bus_if.muldiv_done_i = 1'b0;
    #1;
    check("md_after", 32'(ctl), 32'(C_IDLE));
`ifdef PIPE_STALL_CNT_EN
    check("md_cnt", stall_cnt - cnt_base, 32'd4);
`endif

    // Watchdog, with jump/hazard ignored during wait
    bus_if.muldiv_start_i = 1'b1;
    #1;
    check("wd_c0", 32'(ctl), 32'(C_MD));
    tick();
    bus_if.muldiv_start_i = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (c == 2) begin
        set_load_use(5'd5);
        bus_if.ex_jump_i      = 1'b1;
        bus_if.ex_jump_addr_i = 32'h0000_0200;
      end
      #1;
      check($sformatf("wd_c%0d", c), 32'(ctl), 32'(C_MD));
      if (c == 2) begin
        check("wd_jump_addr", bus_if.pc_jump_addr_o, 32'h0);
        clear_inputs();
      end
      tick();
    end
    #1;
    check("wd_timeout", 32'(ctl), 32'(C_TMO));
    tick();
    #1;
    check("wd_run", 32'(ctl), 32'(C_IDLE));

    // Done on the limit cycle is a normal completion
    bus_if.muldiv_start_i = 1'b1;
    tick();
    bus_if.muldiv_start_i = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      #1;
      check($sformatf("lim_c%0d", c), 32'(ctl), 32'(C_MD));
      tick();
    end
    bus_if.muldiv_done_i = 1'b1;
    #1;
    check("lim_done", 32'(ctl), 32'(C_IDLE));
    tick();
    bus_if.muldiv_done_i = 1'b0;
    #1;
    check("lim_after", 32'(ctl), 32'(C_IDLE));

    // Reset at wait cycle 3
    bus_if.muldiv_start_i = 1'b1;
    tick();
    bus_if.muldiv_start_i = 1'b0;
    tick();
    tick();
    #1;
    check("rw_c3_pre", 32'(ctl), 32'(C_MD));
    rst = 1'b1;
    #1;
    check("rw_c3_rst", 32'(ctl), 32'(C_FLUSH));
    tick();
    #1;
    check("rw_hold", 32'(ctl), 32'(C_FLUSH));
`ifdef PIPE_STALL_CNT_EN
    check("rw_cnt", stall_cnt, 32'h0);
`endif
    tick();
    rst = 1'b0;
    #1;
    check("rw_run", 32'(ctl), 32'(C_IDLE));
    tick();
    #1;
    check("rw_run2", 32'(ctl), 32'(C_IDLE));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
